// File: rtl/common.sv
// rtl/common.sv - shared constants, literal/clause layout and FSM states for the DB kernel
// lit = {var, pol}; clause = {len, lit[MAX_LITS-1], ..., lit[0]}; var 0 marks an empty slot
package common;

    localparam int DBK_VAR_W       = 3;
    localparam int DBK_MAX_LITS    = 5;
    localparam int DBK_MAX_CLAUSES = 10;

    localparam int zero_lit = 0;

    function automatic int lit_w(input int var_w);
        return var_w + 1;
    endfunction

    function automatic int len_w(input int max_lits);
        return $clog2(max_lits + 1);
    endfunction

    function automatic int clause_w(input int var_w, input int max_lits);
        return max_lits * lit_w(var_w) + len_w(max_lits);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PROP,
        ST_DECIDE,
        ST_BTRACK,
        ST_DONE
    } dbk_state_e;

endpackage

// File: rtl/dbk_param_solver_if.sv
// rtl/dbk_param_solver_if.sv - loader/host side signals of the DPLL kernel
interface dbk_param_solver_if #(
    parameter int VAR_W    = common::DBK_VAR_W,
    parameter int MAX_LITS = common::DBK_MAX_LITS,
    parameter int CNT_W    = 16
);
    localparam int CLAUSE_W = common::clause_w(VAR_W, MAX_LITS);

    logic                    clear;
    logic                    load_valid;
    logic [CLAUSE_W-1:0]     load_clause;
    logic                    load_ready;
    logic                    find;
    logic                    propagating;
    logic [VAR_W:0]          out_lit;
    logic                    out_lit_valid;
    logic                    ended;
    logic                    sat;
    logic                    unsat;
    logic [(1<<VAR_W)-1:0]   model;
    logic [CNT_W-1:0]        conflict_count;
    logic [CNT_W-1:0]        decision_count;

    modport master (
        output clear, load_valid, load_clause, find,
        input  load_ready, propagating, out_lit, out_lit_valid, ended, sat, unsat,
               model, conflict_count, decision_count
    );

    modport slave (
        input  clear, load_valid, load_clause, find,
        output load_ready, propagating, out_lit, out_lit_valid, ended, sat, unsat,
               model, conflict_count, decision_count
    );
endinterface

// File: rtl/dbk_clause_eval.sv
// rtl/dbk_clause_eval.sv - combinational clause status against the current partial assignment
module dbk_clause_eval
    import common::*;
#(
    parameter int VAR_W    = DBK_VAR_W,
    parameter int MAX_LITS = DBK_MAX_LITS
) (
    input  logic [clause_w(VAR_W, MAX_LITS)-1:0] clause_i,
    input  logic [(1<<VAR_W)-1:0]               assigned_i,
    input  logic [(1<<VAR_W)-1:0]               value_i,
    output logic                                sat_o,
    output logic                                conflict_o,
    output logic                                unit_o,
    output logic [VAR_W:0]                      unit_lit_o
);
    localparam int LEN_W = len_w(MAX_LITS);

    typedef struct packed {
        logic [VAR_W-1:0] v;
        logic             pol;
    } lit_t;

    typedef struct packed {
        logic [LEN_W-1:0]       len;
        lit_t [MAX_LITS-1:0]    lits;
    } clause_t;

    clause_t cl;
    int      n_free;

    assign cl = clause_t'(clause_i);

    always_comb begin
        sat_o      = 1'b0;
        n_free     = 0;
        unit_lit_o = '0;
        for (int l = 0; l < MAX_LITS; l++) begin
            if (cl.lits[l].v != VAR_W'(zero_lit) && LEN_W'(l) < cl.len) begin
                if (assigned_i[cl.lits[l].v]) begin
                    if (value_i[cl.lits[l].v] == cl.lits[l].pol) sat_o = 1'b1;
                end else begin
                    n_free     = n_free + 1;
                    unit_lit_o = cl.lits[l];
                end
            end
        end
        unit_o     = !sat_o && (n_free == 1);
        conflict_o = !sat_o && (n_free == 0);
    end
endmodule

// File: rtl/dbk_param_solver.sv
// rtl/dbk_param_solver.sv - DPLL kernel: clause store, unit propagation, decide, chronological backtrack
// DBK_STATS_EN enables the conflict/decision counters; without it both read 0.
module dbk_param_solver
    import common::*;
#(
    parameter int VAR_W       = DBK_VAR_W,
    parameter int MAX_LITS    = DBK_MAX_LITS,
    parameter int MAX_CLAUSES = DBK_MAX_CLAUSES,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    dbk_param_solver_if.slave   host
);
    localparam int NV    = 1 << VAR_W;
    localparam int TD    = NV - 1;
    localparam int LEN_W = len_w(MAX_LITS);
    localparam int CI_W  = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;
    localparam int CL_W  = $clog2(MAX_CLAUSES + 1);

    typedef struct packed {
        logic [VAR_W-1:0] v;
        logic             pol;
    } lit_t;

    typedef struct packed {
        logic [LEN_W-1:0]       len;
        lit_t [MAX_LITS-1:0]    lits;
    } clause_t;

    dbk_state_e       state_q;
    clause_t          store_q [MAX_CLAUSES];
    logic [CL_W-1:0]  count_q;
    logic [CI_W-1:0]  idx_q;
    logic [NV-1:0]    assigned_q, value_q;
    logic [VAR_W-1:0] trail_var_q [TD];
    logic             trail_dec_q [TD];
    logic [VAR_W-1:0] tp_q;
    logic             changed_q, allsat_q, armed_q;
    logic [VAR_W:0]   out_lit_q;
    logic             out_lit_valid_q, ended_q, sat_q, unsat_q;

    logic             ev_sat, ev_conflict, ev_unit, last_scan, load_fire;
    logic [VAR_W:0]   unit_lit;
    logic [NV-1:0]    present;
    logic [VAR_W-1:0] dec_var, top_d;

    assign host.load_ready = armed_q && (state_q == ST_IDLE || state_q == ST_LOAD)
                             && count_q < CL_W'(MAX_CLAUSES);
    assign load_fire        = host.load_valid && host.load_ready;
    assign last_scan        = CL_W'(idx_q) == count_q - 1'b1;
    assign top_d            = tp_q - 1'b1;

    assign host.propagating   = state_q == ST_PROP;
    assign host.out_lit       = out_lit_q;
    assign host.out_lit_valid = out_lit_valid_q;
    assign host.ended         = ended_q;
    assign host.sat           = sat_q;
    assign host.unsat         = unsat_q;
    assign host.model         = value_q;

    dbk_clause_eval #(.VAR_W(VAR_W), .MAX_LITS(MAX_LITS)) u_eval (
        .clause_i   (store_q[idx_q]),
        .assigned_i (assigned_q),
        .value_i    (value_q),
        .sat_o      (ev_sat),
        .conflict_o (ev_conflict),
        .unit_o     (ev_unit),
        .unit_lit_o (unit_lit)
    );

    // Decision candidate: lowest unassigned variable that occurs in the stored formula.
    always_comb begin
        present = '0;
        dec_var = '0;
        for (int c = 0; c < MAX_CLAUSES; c++)
            if (CL_W'(c) < count_q)
                for (int l = 0; l < MAX_LITS; l++)
                    if (LEN_W'(l) < store_q[c].len) present[store_q[c].lits[l].v] = 1'b1;
        present[zero_lit] = 1'b0;
        for (int v = NV - 1; v >= 0; v--)
            if (present[v] && !assigned_q[v]) dec_var = VAR_W'(v);
    end

    always_ff @(posedge clock)
        if (load_fire) store_q[count_q[CI_W-1:0]] <= clause_t'(host.load_clause);

`ifdef DBK_STATS_EN
    logic [CNT_W-1:0] conflict_q, decision_q;
    assign host.conflict_count = conflict_q;
    assign host.decision_count = decision_q;
`else
    assign host.conflict_count = {CNT_W{1'b0}};
    assign host.decision_count = {CNT_W{1'b0}};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            idx_q           <= '0;
            assigned_q      <= '0;
            value_q         <= '0;
            tp_q            <= '0;
            changed_q       <= 1'b0;
            allsat_q        <= 1'b0;
            armed_q         <= 1'b0;
            out_lit_q       <= '0;
            out_lit_valid_q <= 1'b0;
            ended_q         <= 1'b0;
            sat_q           <= 1'b0;
            unsat_q         <= 1'b0;
            for (int i = 0; i < TD; i++) begin
                trail_var_q[i] <= '0;
                trail_dec_q[i] <= 1'b0;
            end
`ifdef DBK_STATS_EN
            conflict_q <= '0;
            decision_q <= '0;
`endif
        end else begin
            armed_q         <= 1'b1;
            out_lit_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (state_q == ST_IDLE && host.clear) begin
                        count_q <= '0;
                    end else if (load_fire) begin
                        count_q <= count_q + 1'b1;
                        state_q <= ST_LOAD;
                    end
                    if (host.find) begin
                        state_q    <= ST_PROP;
                        idx_q      <= '0;
                        tp_q       <= '0;
                        assigned_q <= '0;
                        value_q    <= '0;
                        changed_q  <= 1'b0;
                        allsat_q   <= 1'b1;
`ifdef DBK_STATS_EN
                        conflict_q <= '0;
                        decision_q <= '0;
`endif
                    end
                end
                ST_PROP: begin
                    if (count_q == '0) begin
                        state_q <= ST_DONE;
                        ended_q <= 1'b1;
                        sat_q   <= 1'b1;
                    end else if (ev_conflict) begin
                        state_q <= ST_BTRACK;
`ifdef DBK_STATS_EN
                        if (conflict_q != '1) conflict_q <= conflict_q + 1'b1;
`endif
                    end else begin
                        if (ev_unit) begin
                            assigned_q[unit_lit[VAR_W:1]] <= 1'b1;
                            value_q[unit_lit[VAR_W:1]]    <= unit_lit[0];
                            trail_var_q[tp_q]             <= unit_lit[VAR_W:1];
                            trail_dec_q[tp_q]             <= 1'b0;
                            tp_q                          <= tp_q + 1'b1;
                            out_lit_q                     <= unit_lit;
                            out_lit_valid_q               <= 1'b1;
                        end
                        if (last_scan) begin
                            idx_q     <= '0;
                            changed_q <= 1'b0;
                            allsat_q  <= 1'b1;
                            if (!(changed_q || ev_unit)) begin
                                if (allsat_q && ev_sat) begin
                                    state_q <= ST_DONE;
                                    ended_q <= 1'b1;
                                    sat_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_DECIDE;
                                end
                            end
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            changed_q <= changed_q || ev_unit;
                            allsat_q  <= allsat_q && ev_sat;
                        end
                    end
                end
                ST_DECIDE: begin
                    assigned_q[dec_var] <= 1'b1;
                    value_q[dec_var]    <= 1'b0;
                    trail_var_q[tp_q]   <= dec_var;
                    trail_dec_q[tp_q]   <= 1'b1;
                    tp_q                <= tp_q + 1'b1;
                    out_lit_q           <= {dec_var, 1'b0};
                    out_lit_valid_q     <= 1'b1;
                    idx_q               <= '0;
                    state_q             <= ST_PROP;
`ifdef DBK_STATS_EN
                    if (decision_q != '1) decision_q <= decision_q + 1'b1;
`endif
                end
                ST_BTRACK: begin
                    if (tp_q == '0) begin
                        state_q <= ST_DONE;
                        ended_q <= 1'b1;
                        unsat_q <= 1'b1;
                    end else if (trail_dec_q[top_d]) begin
                        // Flipped decision stays on the trail as an implied entry.
                        value_q[trail_var_q[top_d]] <= ~value_q[trail_var_q[top_d]];
                        trail_dec_q[top_d]          <= 1'b0;
                        out_lit_q       <= {trail_var_q[top_d], ~value_q[trail_var_q[top_d]]};
                        out_lit_valid_q <= 1'b1;
                        idx_q           <= '0;
                        changed_q       <= 1'b0;
                        allsat_q        <= 1'b1;
                        state_q         <= ST_PROP;
                    end else begin
                        assigned_q[trail_var_q[top_d]] <= 1'b0;
                        value_q[trail_var_q[top_d]]    <= 1'b0;
                        tp_q                           <= top_d;
                    end
                end
                ST_DONE: begin
                    if (!host.find) begin
                        state_q    <= ST_IDLE;
                        ended_q    <= 1'b0;
                        sat_q      <= 1'b0;
                        unsat_q    <= 1'b0;
                        assigned_q <= '0;
                        value_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbk_param_solver.sv
// tb/tb_dbk_param_solver.sv - directed bench for dbk_param_solver
module tb_dbk_param_solver;

    localparam logic [3:0] X1  = 4'b0011;
    localparam logic [3:0] NX1 = 4'b0010;
    localparam logic [3:0] X2  = 4'b0101;
    localparam logic [3:0] NX2 = 4'b0100;
    localparam logic [3:0] X3  = 4'b0111;
    localparam logic [3:0] NL  = 4'b0000;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [3:0] exp_lits[$];
    logic [3:0] obs_lits[$];

    dbk_param_solver_if #(.VAR_W(3), .MAX_LITS(5), .CNT_W(16)) host ();

    dbk_param_solver #(.VAR_W(3), .MAX_LITS(5), .MAX_CLAUSES(10), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .host  (host)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int stat(input int v);
`ifdef DBK_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [22:0] mkc(input logic [2:0] len, input logic [3:0] l0,
                                        input logic [3:0] l1, input logic [3:0] l2);
        return {len, 4'h0, 4'h0, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [22:0] c);
        host.load_valid  = 1'b1;
        host.load_clause = c;
        tick();
        host.load_valid  = 1'b0;
    endtask

    task automatic do_clear();
        host.clear = 1'b1;
        tick();
        host.clear = 1'b0;
    endtask

    task automatic run_solve(input string tag, input int exp_cyc, input logic exp_sat,
                             input logic [7:0] exp_model, input int exp_conf, input int exp_dec);
        int cyc;
        bit done;
        obs_lits.delete();
        host.find = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
            host.load_valid = 1'b0;
            if (cyc == 1) check({tag, "_prop"}, 32'(host.propagating), 32'd1);
            if (host.out_lit_valid) obs_lits.push_back(host.out_lit);
            if (host.ended) done = 1'b1;
        end
        check({tag, "_ended"}, 32'(done), 32'd1);
        if (exp_cyc >= 0) check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_sat"}, 32'(host.sat), 32'(exp_sat));
        check({tag, "_unsat"}, 32'(host.unsat), 32'(!exp_sat));
        check({tag, "_model"}, 32'(host.model), 32'(exp_model));
        check({tag, "_nlits"}, 32'(obs_lits.size()), 32'(exp_lits.size()));
        for (int i = 0; i < exp_lits.size(); i++)
            check($sformatf("%s_lit%0d", tag, i),
                  (i < obs_lits.size()) ? 32'(obs_lits[i]) : 32'h1f, 32'(exp_lits[i]));
        check({tag, "_conf"}, 32'(host.conflict_count), 32'(stat(exp_conf)));
        check({tag, "_dec"}, 32'(host.decision_count), 32'(stat(exp_dec)));
        tick();
        check({tag, "_hold_ended"}, 32'(host.ended), 32'd1);
        check({tag, "_hold_sat"}, 32'(host.sat), 32'(exp_sat));
        host.find = 1'b0;
        tick();
        check({tag, "_idle_ended"}, 32'(host.ended), 32'd0);
        check({tag, "_idle_res"}, 32'({host.sat, host.unsat}), 32'd0);
    endtask

    task automatic load_xor4();
        load(mkc(3'd2, X1, X2, NL));
        load(mkc(3'd2, NX1, X2, NL));
        load(mkc(3'd2, X1, NX2, NL));
        load(mkc(3'd2, NX1, NX2, NL));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        host.clear       = 1'b0;
        host.load_valid  = 1'b0;
        host.load_clause = '0;
        host.find        = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(host.load_ready), 32'd0);
        check("rst_ended", 32'({host.ended, host.sat, host.unsat}), 32'd0);
        check("rst_model", 32'(host.model), 32'd0);
        check("rst_prop", 32'(host.propagating), 32'd0);
        check("rst_lit", 32'({host.out_lit, host.out_lit_valid}), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_ready", 32'(host.load_ready), 32'd1);

        // {x1}
        load(mkc(3'd1, X1, NL, NL));
        exp_lits = '{X1};
        run_solve("unit", 3, 1'b1, 8'h02, 0, 0);

        // {x1},{~x1}
        do_clear();
        load(mkc(3'd1, X1, NL, NL));
        load(mkc(3'd1, NX1, NL, NL));
        exp_lits = '{X1};
        run_solve("contra", 5, 1'b0, 8'h00, 1, 0);

        // empty store
        do_clear();
        exp_lits.delete();
        run_solve("empty", 2, 1'b1, 8'h00, 0, 0);

        // (x3 | - | x2): decides x2 (x1 absent), then implies x3
        do_clear();
        load(mkc(3'd3, X3, NL, X2));
        exp_lits = '{NX2, X3};
        run_solve("decide", 5, 1'b1, 8'h08, 0, 1);

        // all four 2-clauses over x1,x2
        do_clear();
        load_xor4();
        exp_lits = '{NX1, X2, X1, X2};
        run_solve("xor4", 18, 1'b0, 8'h00, 2, 1);

        // 11 back-to-back offers; the 11th ({~x1}) must be dropped
        do_clear();
        host.load_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            host.load_clause = (i == 10) ? mkc(3'd1, NX1, NL, NL) : mkc(3'd1, X1, NL, NL);
            check($sformatf("fill_ready%0d", i), 32'(host.load_ready), (i < 10) ? 32'd1 : 32'd0);
            tick();
        end
        host.load_valid = 1'b0;
        exp_lits = '{X1};
        run_solve("full", 21, 1'b1, 8'h02, 0, 0);

        // load and find in the same cycle
        do_clear();
        host.load_valid  = 1'b1;
        host.load_clause = mkc(3'd1, X1, NL, NL);
        exp_lits = '{X1};
        run_solve("ldfind", 3, 1'b1, 8'h02, 0, 0);

        // reset while backtracking
        do_clear();
        load_xor4();
        host.find = 1'b1;
        repeat (9) tick();
        check("bt_state", 32'({host.propagating, host.ended}), 32'd0);
        check("bt_model", 32'(host.model), 32'h04);
        #2;
        reset = 1'b1;
        #1;
        check("arst_res", 32'({host.ended, host.sat, host.unsat, host.propagating}), 32'd0);
        check("arst_model", 32'(host.model), 32'd0);
        check("arst_lit", 32'({host.out_lit, host.out_lit_valid}), 32'd0);
        check("arst_ready", 32'(host.load_ready), 32'd0);
        check("arst_cnt", 32'({host.conflict_count, host.decision_count}), 32'd0);
        host.find = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        load_xor4();
        exp_lits = '{NX1, X2, X1, X2};
        run_solve("reload", 18, 1'b0, 8'h00, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dbk_param_solver.md
# dbk_param_solver

Parametrised DPLL kernel, next generation of the fixed 10-clause/5-literal/3-bit-variable DB kernel. Clauses stream in one per cycle into an internal clause store. On `find`, the kernel runs unit propagation, decides and does chronological backtracking on an assignment trail, then reports SAT (with a model) or UNSAT. It sits between the formula loader and the result/host interface of the hardware SAT solver.

## Interface
- `VAR_W`, default 3: variable index width. Variables are 1..2^VAR_W−1; index 0 marks an empty literal slot (`zero_lit`).
- `MAX_LITS`, default 5: literal slots per clause.
- `MAX_CLAUSES`, default 10: clause store depth.
- `CNT_W`, default 16: statistics counter width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state, including the clause count.
- `clear` in 1: in IDLE, empties the clause store (count := 0).
- `load_valid` in 1: `load_clause` is valid.
- `load_clause` in clause: MAX_LITS × {var VAR_W, pol 1}, plus a length field.
- `load_ready` out 1: high in IDLE/LOAD while count < MAX_CLAUSES.
- `find` in 1: start solve; sampled in IDLE/LOAD.
- `propagating` out 1: high in PROPAGATE.
- `out_lit` out VAR_W+1: literal most recently implied or decided.
- `out_lit_valid` out 1: one-cycle pulse per implication/decision.
- `ended`, `sat`, `unsat` out 1: result. Held while in DONE.
- `model` out 2^VAR_W: bit v = value of variable v. Unassigned reads 0. Bit 0 is always 0.
- `conflict_count`, `decision_count` out CNT_W: statistics.
- All outputs reset to 0.

## Operation
- pol=1 means positive literal. A literal is true iff its variable is assigned and value==pol. Slots with var=0 are ignored.
- States: IDLE, LOAD, PROPAGATE, DECIDE, BACKTRACK, DONE.
- IDLE/LOAD: each `load_valid && load_ready` writes the clause at index count, then count++. Loads are ignored when the store is full. `find` → PROPAGATE at clause 0 and clears the trail, assignment, stats and pass flags.
- PROPAGATE: evaluates one clause per cycle. A clause is:
  - satisfied if any literal is true;
  - a conflict if it has no unassigned literal and is not satisfied (this includes empty clauses);
  - a unit if it has exactly one unassigned literal and is not satisfied. The unit literal is assigned, pushed to the trail as implied, raises `out_lit_valid`, and sets the `changed` flag.
- A conflict → BACKTRACK, and `conflict_count`++.
- End of pass, taken on the cycle the last clause is scanned:
  - `changed` → rescan from clause 0;
  - else, every clause satisfied → DONE with `sat`;
  - else → DECIDE.
- count=0 → DONE/sat on the next cycle.
- DECIDE (1 cycle): assign value 0 to the lowest-indexed unassigned variable that appears in the store. Push it as a decision, `decision_count`++, pulse `out_lit`, go to PROPAGATE at clause 0.
- BACKTRACK: pops one trail entry per cycle.
  - Implied entry: unassign it.
  - Unflipped decision: flip its value, re-mark it as implied, pulse `out_lit`, go to PROPAGATE at clause 0.
  - Trail empty → DONE with `unsat`.
- DONE: `ended` plus exactly one of `sat`/`unsat` held. `find` low → IDLE. Results clear in IDLE; the clause store is retained.
- Trail depth is 2^VAR_W−1; it cannot overflow because each variable is on it at most once.
- Counters saturate at 2^CNT_W−1.

## Timing
- Load: 1 clause per cycle, no bubbles.
- `find` → `propagating` high on the next cycle.
- A pass takes count cycles.
- Implication visible in `model` and `out_lit` 1 cycle after its clause is scanned; unit detection sees assignments from earlier cycles of the same pass.
- DECIDE takes 1 cycle; BACKTRACK takes 1 cycle per popped entry.
- `find` held high in DONE keeps the results stable.
- Reset asserted mid-solve: all outputs are 0 immediately, with no partial result.
- `load_valid` together with `find` in the same cycle: the load is committed first and is included in the solve.

## Configuration
- `DBK_STATS_EN`:
  - Defined: `conflict_count` and `decision_count` are live.
  - Undefined: both are tied to 0, with no counter flops. Solver behaviour is otherwise identical.

## Structure
- Package `common`:
  - default constants (DBK_VAR_W, DBK_MAX_LITS, DBK_MAX_CLAUSES);
  - `zero_lit`;
  - the lit/clause field layout.
- The module derives its parametrised `lit`/`clause` typedefs from these.
- One sub-module, `dbk_clause_eval`: combinational. Takes a clause plus the assignment vectors and returns satisfied, conflict, unit and the unit literal.

## Test plan
- Load {x1}, `find` → one `out_lit_valid` with {1,1}; `ended`, `sat` high; model[1]=1; decisions=0.
- Load {x1},{¬x1} → `unsat` with no decisions; conflicts=1.
- count=0, `find` → `sat` 2 cycles after `find`; model=0.
- Load (x1∨x2), (¬x1∨x2), (x1∨¬x2), (¬x1∨¬x2) → `out_lit` sequence {1,0}, {2,1}, {1,1}, {2,1}; then `unsat`; conflicts=2, decisions=1.
- MAX_CLAUSES=10: offer 11 clauses back-to-back → `load_ready` low after the 10th; the 11th is not stored.
- Assert `reset` during BACKTRACK → all outputs 0 asynchronously. After reload, the same formula gives the same result.
